mips_cpu_alu_arbiter: RTL and testbench
=======================================

// Module: mips_cpu_alu_arbiter
// PURPOSE
//  Shares a single mips_cpu_ALU instance between two requesters (req0: execute stage, req1: address/branch-target unit).
//  Arbitrates round-robin, registers operands, drives the ALU, captures result/zero and returns them on one tagged
//  response channel with valid/ready flow control. Sits between the requesters and the ALU; contains no arithmetic.
// PARAMETERS
//  DATA_W   32  operand/result width (must match ALU)
//  OP_W     5   ALU opcode width
//  MAX_OP   8   highest legal ALU opcode; op > MAX_OP is illegal
//  FAIR     1   1 = round-robin between requesters; 0 = fixed priority, req0 always wins
// PORTS
//  clk           in   1       clock, all state updates on rising edge
//  reset         in   1       synchronous, active-high reset
//  r0_valid      in   1       requester 0 has an operation
//  r0_ready      out  1       requester 0 operation accepted this cycle (when r0_valid & r0_ready)
//  r0_op/r0_a/r0_b/r0_sa  in  OP_W/DATA_W/DATA_W/5  requester 0 operation fields
//  r1_valid, r1_ready, r1_op, r1_a, r1_b, r1_sa     same as above for requester 1
//  rsp_valid     out  1       response available
//  rsp_ready     in   1       consumer accepts response (when rsp_valid & rsp_ready)
//  rsp_owner     out  1       index of requester the response belongs to
//  rsp_result    out  DATA_W  captured ALU result
//  rsp_zero      out  1       captured ALU zero flag
//  rsp_err       out  1       1 = illegal opcode, result forced to 0, ALU not used
//  alu_op/alu_a/alu_b/alu_sa  out  OP_W/DATA_W/DATA_W/5  registered operands to ALU
//  alu_result    in   DATA_W  ALU result (combinational from alu_* outputs)
//  alu_zero      in   1       ALU zero flag
// BEHAVIOUR
//  FSM states: IDLE, EXEC, RESP. Reset -> IDLE.
//  IDLE: grant = arbitration of r0_valid/r1_valid; rX_ready = 1 only for granted requester, 0 for other.
//   rX_ready is combinational from rX_valid and state; both readies are 0 outside IDLE.
//   Only one requester valid -> it is granted. Both valid, FAIR=1 -> grant the one not granted last
//   (last_grant pointer, reset value 1, so req0 wins the first contention). FAIR=0 -> req0.
//   On handshake: latch op/a/b/sa into alu_* regs, latch owner, update last_grant.
//    Legal op -> EXEC. Illegal op (op > MAX_OP) -> RESP directly with rsp_err=1, rsp_result=0, rsp_zero=1.
//  EXEC: ALU evaluates the latched operands; at the clock edge capture alu_result/alu_zero into rsp regs, rsp_err=0 -> RESP.
//  RESP: rsp_valid=1; result/zero/owner/err stable until handshake. rsp_valid & rsp_ready -> IDLE.
//   No new request is accepted in RESP or EXEC (single outstanding operation).
//  Latency: accept in cycle N -> rsp_valid in cycle N+2 (legal op) or N+1 (illegal op).
//   Minimum issue interval 3 cycles with rsp_ready held high.
//  alu_* outputs hold last latched values between operations (no toggling while idle).
//  Reset values: state IDLE, rsp_valid 0, rsp_owner 0, rsp_result 0, rsp_zero 0, rsp_err 0, alu_op/a/b/sa 0,
//   last_grant 1, r0_ready/r1_ready 0 while reset asserted.
//  Reset mid-operation (EXEC or RESP): operation is discarded, no response is produced, all above values restored next edge.
//  Requester deasserting valid before ready: legal, nothing latched. Fields must be stable only in the handshake cycle.
//  rsp_ready high while rsp_valid low: ignored.
// TESTING
//  T1 reset, r0: op=2 a=5 b=7 -> r0_ready same cycle; 2 cycles later rsp_valid, owner 0, result 12, zero 0, err 0.
//  T2 r0 and r1 valid together from reset (r0 op=3 a=9 b=9, r1 op=1 a=0xF0 b=0x0F) -> r0 served first
//     (result 0, zero 1), then r1 (result 0xFF); alternates on further contention.
//  T3 r1: op=9 -> rsp in 1 cycle, err 1, result 0, zero 1, alu_* unchanged.
//  T4 rsp_ready held low 10 cycles after rsp_valid -> response fields stable, both readies 0, no new grant;
//     release -> IDLE and next request is accepted.
//  T5 reset asserted in EXEC and again in RESP -> no rsp_valid pulse, all outputs at reset values, next grant goes to r0.
//  T6 FAIR=0, r0 and r1 continuously valid -> r1 never granted; r0 op=6 b=1 sa=4 -> result 16.

Source files
------------

// File: rtl/mips_cpu_alu_arbiter.sv
// mips_cpu_alu_arbiter
// Lets two requesters share one mips_cpu_ALU. Requester 0 is the execute
// stage and requester 1 is the address/branch-target unit. Only one operation
// is in flight at a time. An accepted operation is registered onto the alu_*
// outputs, and the ALU's combinational result is captured one cycle later.
// The result is then held on a tagged response channel that uses valid/ready
// flow control. This block contains no arithmetic.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   r0_valid/r0_ready           requester 0 handshake (ready is combinational)
//   r0_op/r0_a/r0_b/r0_sa       requester 0 operation fields
//   r1_*                        same for requester 1
//   rsp_valid/rsp_ready         response handshake
//   rsp_owner                   requester index the response belongs to
//   rsp_result/rsp_zero/rsp_err captured ALU result, zero flag, illegal-op flag
//   alu_op/alu_a/alu_b/alu_sa   registered operands driven to the ALU
//   alu_result/alu_zero         ALU outputs (combinational from alu_*)
module mips_cpu_alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5,
    parameter int MAX_OP = 8,
    parameter int FAIR   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [OP_W-1:0]   r0_op,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic [4:0]        r0_sa,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [OP_W-1:0]   r1_op,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic [4:0]        r1_sa,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_owner,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_sa,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [4:0]        sa;
    } req_t;

    localparam logic [OP_W-1:0] MAX_OP_V = OP_W'(MAX_OP);

    state_t state, state_nxt;
    logic   last_grant;   // 1 = requester 1 was granted most recently
    logic   gnt;          // requester picked this cycle
    logic   accept;       // handshake with the granted requester
    logic   illegal;
    req_t   sel;

    // Arbitration. On contention the round-robin pointer gives the grant to
    // the requester that was not served last. last_grant resets to 1, so
    // requester 0 wins the first contention after reset.
    always_comb begin
        if (r0_valid && r1_valid)
            gnt = (FAIR != 0) ? ~last_grant : 1'b0;
        else
            gnt = r1_valid;
        accept   = (state == IDLE) && !reset && (r0_valid || r1_valid);
        r0_ready = accept && !gnt;
        r1_ready = accept && gnt;
        sel      = gnt ? {r1_op, r1_a, r1_b, r1_sa} : {r0_op, r0_a, r0_b, r0_sa};
        illegal  = sel.op > MAX_OP_V;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = illegal ? RESP : EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rsp_owner  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sa     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rsp_owner  <= gnt;
                last_grant <= gnt;
                if (illegal) begin
                    // The ALU is bypassed. alu_* keep their previous operands
                    // so the ALU inputs do not toggle.
                    rsp_err    <= 1'b1;
                    rsp_result <= '0;
                    rsp_zero   <= 1'b1;
                end else begin
                    alu_op <= sel.op;
                    alu_a  <= sel.a;
                    alu_b  <= sel.b;
                    alu_sa <= sel.sa;
                end
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_alu_arbiter.sv
// Bench for mips_cpu_alu_arbiter. u0 uses round-robin arbitration and u1 uses
// fixed priority. Each instance is driven by its own stand-in ALU.
module tb_mips_cpu_alu_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        r0_valid, r1_valid, rsp_ready;
    logic [4:0]  r0_op, r1_op, r0_sa, r1_sa;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;

    logic        u0_r0_ready, u0_r1_ready, u0_rsp_valid, u0_rsp_owner, u0_rsp_zero, u0_rsp_err, u0_alu_zero;
    logic [31:0] u0_rsp_result, u0_alu_a, u0_alu_b, u0_alu_result;
    logic [4:0]  u0_alu_op, u0_alu_sa;
    logic        u1_r0_ready, u1_r1_ready, u1_rsp_valid, u1_rsp_owner, u1_rsp_zero, u1_rsp_err, u1_alu_zero;
    logic [31:0] u1_rsp_result, u1_alu_a, u1_alu_b, u1_alu_result;
    logic [4:0]  u1_alu_op, u1_alu_sa;

    mips_cpu_alu_arbiter #(.DATA_W(32), .OP_W(5), .MAX_OP(8), .FAIR(1)) u0 (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(u0_r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b), .r0_sa(r0_sa),
        .r1_valid(r1_valid), .r1_ready(u0_r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b), .r1_sa(r1_sa),
        .rsp_valid(u0_rsp_valid), .rsp_ready(rsp_ready), .rsp_owner(u0_rsp_owner),
        .rsp_result(u0_rsp_result), .rsp_zero(u0_rsp_zero), .rsp_err(u0_rsp_err),
        .alu_op(u0_alu_op), .alu_a(u0_alu_a), .alu_b(u0_alu_b), .alu_sa(u0_alu_sa),
        .alu_result(u0_alu_result), .alu_zero(u0_alu_zero)
    );

    mips_cpu_alu_arbiter #(.DATA_W(32), .OP_W(5), .MAX_OP(8), .FAIR(0)) u1 (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(u1_r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b), .r0_sa(r0_sa),
        .r1_valid(r1_valid), .r1_ready(u1_r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b), .r1_sa(r1_sa),
        .rsp_valid(u1_rsp_valid), .rsp_ready(rsp_ready), .rsp_owner(u1_rsp_owner),
        .rsp_result(u1_rsp_result), .rsp_zero(u1_rsp_zero), .rsp_err(u1_rsp_err),
        .alu_op(u1_alu_op), .alu_a(u1_alu_a), .alu_b(u1_alu_b), .alu_sa(u1_alu_sa),
        .alu_result(u1_alu_result), .alu_zero(u1_alu_zero)
    );

    // Stand-in ALU: and, or, add, sub, slt, nor, sll, srl, sra.
    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sa);
        case (op)
            5'd0: return a & b;
            5'd1: return a | b;
            5'd2: return a + b;
            5'd3: return a - b;
            5'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd5: return ~(a | b);
            5'd6: return b << sa;
            5'd7: return b >> sa;
            5'd8: return 32'($signed(b) >>> sa);
            default: return 32'd0;
        endcase
    endfunction

    assign u0_alu_result = alu_f(u0_alu_op, u0_alu_a, u0_alu_b, u0_alu_sa);
    assign u0_alu_zero   = (u0_alu_result == 32'd0);
    assign u1_alu_result = alu_f(u1_alu_op, u1_alu_a, u1_alu_b, u1_alu_sa);
    assign u1_alu_zero   = (u1_alu_result == 32'd0);

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        r0_valid = 1'b0; r0_op = '0; r0_a = '0; r0_b = '0; r0_sa = '0;
        r1_valid = 1'b0; r1_op = '0; r1_a = '0; r1_b = '0; r1_sa = '0;
        rsp_ready = 1'b1;
    endtask

    // Holds reset for two edges and returns just after an edge with reset low.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic drive(input bit who, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sa);
        if (!who) begin
            r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b; r0_sa = sa;
        end else begin
            r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b; r1_sa = sa;
        end
    endtask

    // Call this just after a clock edge, with u0 idle and requests driven.
    // The task checks the grant, drops the granted valid after the handshake,
    // measures the latency and checks the response. When consume is set it
    // returns just after the response handshake edge. Otherwise it returns at
    // the falling edge where rsp_valid was first seen.
    task automatic serve(input string tag, input bit owner, input logic [31:0] res, input bit zero,
                         input bit err, input int lat, input bit consume);
        int n;
        @(negedge clk);
        chk({tag, ".grant"}, {u0_r0_ready, u0_r1_ready}, owner ? 2'b01 : 2'b10);
        @(posedge clk); #1;
        if (owner) r1_valid = 1'b0; else r0_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!u0_rsp_valid && n < 6) begin
            chk({tag, ".busy_rdy"}, {u0_r0_ready, u0_r1_ready}, 2'b00);
            @(posedge clk); #1;
            n++;
            @(negedge clk);
        end
        chk({tag, ".latency"}, n, lat);
        chk({tag, ".owner"}, u0_rsp_owner, owner);
        chk({tag, ".result"}, u0_rsp_result, res);
        chk({tag, ".zero"}, u0_rsp_zero, zero);
        chk({tag, ".err"}, u0_rsp_err, err);
        chk({tag, ".resp_rdy"}, {u0_r0_ready, u0_r1_ready}, 2'b00);
        if (consume) begin
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        bit          who;
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [4:0]  sa;
        logic [31:0] res;
        bit          zero, err;
        int          lat;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [4:0]  sv_op;
        logic [31:0] sv_a;
        int g0, g1, nr;

        vt[0] = '{1'b0, 5'd2,  32'd5,          32'd7,          5'd0,  32'd12,         1'b0, 1'b0, 2};
        vt[1] = '{1'b1, 5'd0,  32'hFF00FF00,   32'h0FF00FF0,   5'd0,  32'h0F000F00,   1'b0, 1'b0, 2};
        vt[2] = '{1'b0, 5'd3,  32'd5,          32'd7,          5'd0,  32'hFFFFFFFE,   1'b0, 1'b0, 2};
        vt[3] = '{1'b1, 5'd4,  32'hFFFFFFFF,   32'd1,          5'd0,  32'd1,          1'b0, 1'b0, 2};
        vt[4] = '{1'b0, 5'd5,  32'd0,          32'd0,          5'd0,  32'hFFFFFFFF,   1'b0, 1'b0, 2};
        vt[5] = '{1'b1, 5'd7,  32'd0,          32'h80000000,   5'd31, 32'd1,          1'b0, 1'b0, 2};
        vt[6] = '{1'b0, 5'd8,  32'd0,          32'h80000000,   5'd4,  32'hF8000000,   1'b0, 1'b0, 2};
        vt[7] = '{1'b1, 5'd9,  32'd3,          32'd4,          5'd1,  32'd0,          1'b1, 1'b1, 1};
        vt[8] = '{1'b0, 5'd31, 32'd3,          32'd4,          5'd1,  32'd0,          1'b1, 1'b1, 1};
        vt[9] = '{1'b0, 5'd2,  32'hFFFFFFFF,   32'd1,          5'd0,  32'd0,          1'b1, 1'b0, 2};

        // Reset state: a request during reset must not be accepted.
        idle_inputs();
        reset = 1'b1;
        r0_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst.ready", {u0_r0_ready, u0_r1_ready}, 2'b00);
        chk("rst.rsp", {u0_rsp_valid, u0_rsp_owner, u0_rsp_zero, u0_rsp_err, u0_rsp_result}, 36'd0);
        chk("rst.alu", {u0_alu_op, u0_alu_a, u0_alu_b, u0_alu_sa}, 74'd0);
        do_reset();

        // Single-requester operations, including the opcode boundary and illegal ops.
        for (int i = 0; i < 10; i++) begin
            sv_op = u0_alu_op;
            sv_a  = u0_alu_a;
            drive(vt[i].who, vt[i].op, vt[i].a, vt[i].b, vt[i].sa);
            serve($sformatf("vec%0d", i), vt[i].who, vt[i].res, vt[i].zero, vt[i].err, vt[i].lat, 1'b1);
            if (vt[i].err) begin
                chk($sformatf("vec%0d.alu_hold", i), {u0_alu_op, u0_alu_a}, {sv_op, sv_a});
            end else begin
                chk($sformatf("vec%0d.alu_ops", i), {u0_alu_op, u0_alu_a, u0_alu_b, u0_alu_sa},
                    {vt[i].op, vt[i].a, vt[i].b, vt[i].sa});
            end
        end

        // Contention from reset: r0 first, then r1, then alternating.
        do_reset();
        drive(1'b0, 5'd3, 32'd9, 32'd9, 5'd0);
        drive(1'b1, 5'd1, 32'hF0, 32'h0F, 5'd0);
        serve("t2a", 1'b0, 32'd0, 1'b1, 1'b0, 2, 1'b1);
        serve("t2b", 1'b1, 32'hFF, 1'b0, 1'b0, 2, 1'b1);
        drive(1'b0, 5'd2, 32'd1, 32'd1, 5'd0);
        drive(1'b1, 5'd2, 32'd2, 32'd2, 5'd0);
        serve("t2c", 1'b0, 32'd2, 1'b0, 1'b0, 2, 1'b1);
        drive(1'b0, 5'd2, 32'd1, 32'd1, 5'd0);
        serve("t2d", 1'b1, 32'd4, 1'b0, 1'b0, 2, 1'b1);
        serve("t2e", 1'b0, 32'd2, 1'b0, 1'b0, 2, 1'b1);

        // Backpressure: the response holds and no grant is made while stalled.
        rsp_ready = 1'b0;
        drive(1'b0, 5'd2, 32'd3, 32'd4, 5'd0);
        serve("t4", 1'b0, 32'd7, 1'b0, 1'b0, 2, 1'b0);
        drive(1'b1, 5'd2, 32'd10, 32'd20, 5'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("t4.hold", {u0_rsp_valid, u0_rsp_owner, u0_rsp_zero, u0_rsp_err, u0_rsp_result}, {4'b1000, 32'd7});
            chk("t4.no_grant", {u0_r0_ready, u0_r1_ready}, 2'b00);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        serve("t4b", 1'b1, 32'd30, 1'b0, 1'b0, 2, 1'b1);

        // Reset during EXEC (r1 legal op), then during RESP (r0 illegal op).
        drive(1'b1, 5'd2, 32'd1, 32'd1, 5'd0);
        @(negedge clk);
        chk("t5.grant_exec", u0_r1_ready, 1'b1);
        @(posedge clk); #1;
        r1_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5.no_rsp_exec", u0_rsp_valid, 1'b0);
            @(posedge clk); #1;
        end
        chk("t5.rsp_vals", {u0_rsp_owner, u0_rsp_zero, u0_rsp_err, u0_rsp_result}, 35'd0);
        chk("t5.alu_vals", {u0_alu_op, u0_alu_a, u0_alu_b, u0_alu_sa}, 74'd0);
        drive(1'b0, 5'd31, 32'd5, 32'd5, 5'd0);
        @(negedge clk);
        chk("t5.grant_resp", u0_r0_ready, 1'b1);
        @(posedge clk); #1;
        r0_valid = 1'b0;
        @(negedge clk);
        chk("t5.in_resp", u0_rsp_valid, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5.no_rsp_resp", {u0_rsp_valid, u0_rsp_err, u0_rsp_zero, u0_rsp_owner}, 4'b0000);
            @(posedge clk); #1;
        end
        drive(1'b0, 5'd2, 32'd1, 32'd2, 5'd0);
        drive(1'b1, 5'd2, 32'd3, 32'd4, 5'd0);
        serve("t5c", 1'b0, 32'd3, 1'b0, 1'b0, 2, 1'b1);

        // Fixed priority (u1): r0 continuously valid starves r1.
        do_reset();
        drive(1'b0, 5'd6, 32'd0, 32'd1, 5'd4);
        drive(1'b1, 5'd2, 32'd8, 32'd8, 5'd0);
        g0 = 0; g1 = 0; nr = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (u1_r0_ready) g0++;
            if (u1_r1_ready) g1++;
            if (u1_rsp_valid) begin
                nr++;
                chk("t6.rsp", {u1_rsp_owner, u1_rsp_err, u1_rsp_result}, {2'b00, 32'd16});
            end
            @(posedge clk); #1;
        end
        chk("t6.r1_grants", g1, 0);
        chk("t6.r0_grants", g0, 4);
        chk("t6.responses", nr, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
